// File: rtl/watch_cal_pkg.sv
// Shared calendar types and helpers: weekday encoding, load FSM states,
// Gregorian leap rule and month lengths.
package watch_cal_pkg;

    localparam logic [2:0] WK_SAT = 3'd0, WK_SUN = 3'd1, WK_MON = 3'd2, WK_TUE = 3'd3,
                           WK_WED = 3'd4, WK_THU = 3'd5, WK_FRI = 3'd6;

    typedef enum logic [1:0] {ST_IDLE, ST_VALIDATE, ST_WEEK, ST_COMMIT} cal_state_t;

    function automatic logic is_leap(input logic [31:0] y);
        return ((y % 32'd4 == 32'd0) && (y % 32'd100 != 32'd0)) || (y % 32'd400 == 32'd0);
    endfunction

    function automatic logic [4:0] days_in_month(input logic [3:0] m, input logic leap);
        case (m)
            4'd2:                                       return leap ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:                    return 5'd30;
            4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: return 5'd31;
            default:                                    return 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/cal_weekday.sv
// Combinational Zeller weekday (0 = Saturday) for a Gregorian date.
// The -2J term is folded to +5J so everything stays unsigned.
module cal_weekday #(
    parameter int YEAR_W = 14
) (
    input  logic [YEAR_W-1:0] year,
    input  logic [3:0]        month,
    input  logic [4:0]        day,
    output logic [2:0]        week
);
    localparam int W = YEAR_W + 4;

    logic [W-1:0] y, m, k, j, sum;

    always_comb begin
        // Jan/Feb count as months 13/14 of the previous year
        y   = (month <= 4'd2) ? W'(year) - W'(1) : W'(year);
        m   = (month <= 4'd2) ? W'(month) + W'(12) : W'(month);
        k   = y % W'(100);
        j   = y / W'(100);
        sum = W'(day) + (W'(13) * (m + W'(1))) / W'(5) + k + k / W'(4) + j / W'(4) + W'(5) * j;
        week = 3'(sum % W'(7));
    end

endmodule

// File: rtl/watch_calendar.sv
// Calendar counter with validated load handshake and configurable year range.
// Optional day-retreat input dis_day when WATCH_CAL_DEC_EN is defined.
module watch_calendar
    import watch_cal_pkg::*;
#(
    parameter int YEAR_W    = 14,
    parameter int YEAR_MIN  = 1,
    parameter int YEAR_MAX  = 9999,
    parameter int WRAP_MODE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_day,
`ifdef WATCH_CAL_DEC_EN
    input  logic              dis_day,
`endif
    input  logic              set_valid,
    output logic              set_ready,
    input  logic [YEAR_W+8:0] set_date,
    output logic              set_err,
    output logic [YEAR_W-1:0] year,
    output logic [3:0]        month,
    output logic [4:0]        day,
    output logic [2:0]        week,
    output logic [4:0]        max_date,
    output logic              leap_year,
    output logic              new_year,
    output logic              sat_flag
);
    localparam logic [YEAR_W-1:0] Y_MIN = YEAR_W'(YEAR_MIN);
    localparam logic [YEAR_W-1:0] Y_MAX = YEAR_W'(YEAR_MAX);

    cal_state_t        state, state_nxt;
    logic [YEAR_W-1:0] l_year, n_year;
    logic [3:0]        l_month, n_month;
    logic [4:0]        l_day, n_day;
    logic [2:0]        l_week, calc_week, wk_min, n_week;
    logic              l_ok, accept, pend_inc, go_inc, step, n_ny, n_sat;

    assign set_ready = (state == ST_IDLE);
    assign accept    = set_valid && set_ready;
    assign leap_year = is_leap(32'(year));
    assign max_date  = days_in_month(month, leap_year);
    assign go_inc    = en_day | pend_inc;

    assign l_ok = (l_year >= Y_MIN) && (l_year <= Y_MAX) &&
                  (l_month >= 4'd1) && (l_month <= 4'd12) && (l_day >= 5'd1) &&
                  (l_day <= days_in_month(l_month, is_leap(32'(l_year))));

    // constant inputs: folds to the reset weekday at elaboration
    cal_weekday #(.YEAR_W(YEAR_W)) u_wd_min (
        .year(Y_MIN), .month(4'd1), .day(5'd1), .week(wk_min));

    cal_weekday #(.YEAR_W(YEAR_W)) u_wd_load (
        .year(l_year), .month(l_month), .day(l_day), .week(calc_week));

`ifdef WATCH_CAL_DEC_EN
    logic       pend_dec, go_dec;
    logic [2:0] wk_max;

    assign go_dec = dis_day | pend_dec;
    assign step   = go_inc ^ go_dec;

    cal_weekday #(.YEAR_W(YEAR_W)) u_wd_max (
        .year(Y_MAX), .month(4'd12), .day(5'd31), .week(wk_max));
`else
    assign step = go_inc;
`endif

    always_comb begin
        n_year  = year;
        n_month = month;
        n_day   = day;
        n_week  = (week == WK_FRI) ? WK_SAT : week + 3'd1;
        n_ny    = 1'b0;
        n_sat   = 1'b0;
        if (day < max_date) begin
            n_day = day + 5'd1;
        end else if (month < 4'd12) begin
            n_month = month + 4'd1;
            n_day   = 5'd1;
        end else if (year < Y_MAX) begin
            n_year  = year + YEAR_W'(1);
            n_month = 4'd1;
            n_day   = 5'd1;
            n_ny    = 1'b1;
        end else if (WRAP_MODE == 0) begin
            n_year  = Y_MIN;
            n_month = 4'd1;
            n_day   = 5'd1;
            n_week  = wk_min;
            n_ny    = 1'b1;
        end else begin
            n_week = week;
            n_sat  = 1'b1;
        end
`ifdef WATCH_CAL_DEC_EN
        // only used when go_dec alone is active (step = go_inc ^ go_dec)
        if (go_dec) begin
            n_year  = year;
            n_month = month;
            n_day   = day;
            n_week  = (week == WK_SAT) ? WK_FRI : week - 3'd1;
            n_ny    = 1'b0;
            n_sat   = 1'b0;
            if (day > 5'd1) begin
                n_day = day - 5'd1;
            end else if (month > 4'd1) begin
                n_month = month - 4'd1;
                n_day   = days_in_month(month - 4'd1, leap_year);
            end else if (year > Y_MIN) begin
                n_year  = year - YEAR_W'(1);
                n_month = 4'd12;
                n_day   = 5'd31;
            end else if (WRAP_MODE == 0) begin
                n_year  = Y_MAX;
                n_month = 4'd12;
                n_day   = 5'd31;
                n_week  = wk_max;
            end else begin
                n_week = week;
                n_sat  = 1'b1;
            end
        end
`endif
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (accept) state_nxt = ST_VALIDATE;
            ST_VALIDATE: state_nxt = l_ok ? ST_WEEK : ST_IDLE;
            ST_WEEK:     state_nxt = ST_COMMIT;
            ST_COMMIT:   state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            year     <= Y_MIN;
            month    <= 4'd1;
            day      <= 5'd1;
            week     <= wk_min;
            set_err  <= 1'b0;
            new_year <= 1'b0;
            sat_flag <= 1'b0;
            pend_inc <= 1'b0;
            l_year   <= Y_MIN;
            l_month  <= 4'd1;
            l_day    <= 5'd1;
            l_week   <= WK_SAT;
`ifdef WATCH_CAL_DEC_EN
            pend_dec <= 1'b0;
`endif
        end else begin
            set_err  <= 1'b0;
            new_year <= 1'b0;
            // ticks apply only in an IDLE cycle without an accept; otherwise they park
            if (state == ST_IDLE && !accept) begin
                pend_inc <= 1'b0;
`ifdef WATCH_CAL_DEC_EN
                pend_dec <= 1'b0;
`endif
                if (step) begin
                    year     <= n_year;
                    month    <= n_month;
                    day      <= n_day;
                    week     <= n_week;
                    new_year <= n_ny;
                    if (n_sat) sat_flag <= 1'b1;
                end
            end else begin
                pend_inc <= pend_inc | en_day;
`ifdef WATCH_CAL_DEC_EN
                pend_dec <= pend_dec | dis_day;
`endif
            end
            if (accept) begin
                l_year   <= set_date[YEAR_W+8:9];
                l_month  <= set_date[8:5];
                l_day    <= set_date[4:0];
                sat_flag <= 1'b0;
            end
            if (state == ST_VALIDATE && !l_ok) set_err <= 1'b1;
            if (state == ST_WEEK) l_week <= calc_week;
            if (state == ST_COMMIT) begin
                year  <= l_year;
                month <= l_month;
                day   <= l_day;
                week  <= l_week;
            end
        end
    end

endmodule

// File: tb/tb_watch_calendar.sv
// Directed bench for watch_calendar; a second instance runs WRAP_MODE=1 in lockstep.
module tb_watch_calendar;
    localparam int YW = 14;

    logic          clk = 1'b0, rst = 1'b1, en_day = 1'b0, set_valid = 1'b0;
    logic [YW+8:0] set_date = '0;
    logic          set_ready, set_err, leap_year, new_year, sat_flag;
    logic [YW-1:0] year;
    logic [3:0]    month;
    logic [4:0]    day, max_date;
    logic [2:0]    week;
    logic          s_set_ready, s_set_err, s_leap_year, s_new_year, s_sat_flag;
    logic [YW-1:0] s_year;
    logic [3:0]    s_month;
    logic [4:0]    s_day, s_max_date;
    logic [2:0]    s_week;
    int            n_chk = 0, n_err = 0;

    watch_calendar #(.YEAR_W(YW), .YEAR_MIN(1), .YEAR_MAX(9999), .WRAP_MODE(0)) dut (
        .clk(clk), .rst(rst), .en_day(en_day), .set_valid(set_valid), .set_ready(set_ready),
        .set_date(set_date), .set_err(set_err), .year(year), .month(month), .day(day),
        .week(week), .max_date(max_date), .leap_year(leap_year), .new_year(new_year),
        .sat_flag(sat_flag));

    watch_calendar #(.YEAR_W(YW), .YEAR_MIN(1), .YEAR_MAX(9999), .WRAP_MODE(1)) dut_s (
        .clk(clk), .rst(rst), .en_day(en_day), .set_valid(set_valid), .set_ready(s_set_ready),
        .set_date(set_date), .set_err(s_set_err), .year(s_year), .month(s_month), .day(s_day),
        .week(s_week), .max_date(s_max_date), .leap_year(s_leap_year), .new_year(s_new_year),
        .sat_flag(s_sat_flag));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_date(input string tag, input int y, input int m, input int d, input int w);
        chk({tag, ".year"},  32'(year),  y);
        chk({tag, ".month"}, 32'(month), m);
        chk({tag, ".day"},   32'(day),   d);
        chk({tag, ".week"},  32'(week),  w);
    endtask

    task automatic tick();
        en_day = 1'b1;
        @(negedge clk);
        en_day = 1'b0;
    endtask

    // returns at the negedge right after the accept edge
    task automatic accept_req(input int y, input int m, input int d);
        int n = 0;
        while (!set_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!set_ready) chk("ready_timeout", 32'(set_ready), 1);
        set_date  = {YW'(y), 4'(m), 5'(d)};
        set_valid = 1'b1;
        @(negedge clk);
        set_valid = 1'b0;
    endtask

    task automatic load(input int y, input int m, input int d);
        accept_req(y, m, d);
        repeat (3) @(negedge clk);
    endtask

    task automatic load_bad(input string tag, input int y, input int m, input int d);
        accept_req(y, m, d);
        chk({tag, ".err_e0"}, 32'(set_err), 0);
        @(negedge clk);
        chk({tag, ".err"}, 32'(set_err), 1);
        chk({tag, ".rdy"}, 32'(set_ready), 1);
        @(negedge clk);
        chk({tag, ".err_clr"}, 32'(set_err), 0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_date("rst", 1, 1, 1, 2);
        chk("rst.rdy", 32'(set_ready), 1);
        chk("rst.err", 32'(set_err), 0);
        chk("rst.sat", 32'(sat_flag), 0);
        chk("rst.ny", 32'(new_year), 0);
        chk("rst.max", 32'(max_date), 31);
        chk("rst_s.rdy", 32'(s_set_ready), 1);
        chk("rst_s.err", 32'(s_set_err), 0);
        chk("rst_s.leap", 32'(s_leap_year), 0);
        chk("rst_s.max", 32'(s_max_date), 31);

        load(2024, 2, 28);
        chk_date("ld2024", 2024, 2, 28, 4);
        chk("ld2024.leap", 32'(leap_year), 1);
        chk("ld2024.max", 32'(max_date), 29);
        tick();
        chk_date("feb29", 2024, 2, 29, 5);
        tick();
        chk_date("mar1", 2024, 3, 1, 6);
        chk("mar1.max", 32'(max_date), 31);

        load(1900, 2, 28);
        chk("1900.leap", 32'(leap_year), 0);
        chk("1900.max", 32'(max_date), 28);
        tick();
        chk_date("1900mar1", 1900, 3, 1, 5);

        accept_req(2000, 2, 29);
        chk("2000.rdy_e0", 32'(set_ready), 0);
        @(negedge clk);
        chk("2000.rdy_e1", 32'(set_ready), 0);
        @(negedge clk);
        chk("2000.month_e2", 32'(month), 3);
        @(negedge clk);
        chk_date("2000", 2000, 2, 29, 3);
        chk("2000.rdy_e3", 32'(set_ready), 1);

        load_bad("bad_feb29", 2023, 2, 29);
        load_bad("bad_m13", 2023, 13, 1);
        load_bad("bad_d0", 2023, 1, 0);
        load_bad("bad_y0", 0, 1, 1);
        chk_date("unchanged", 2000, 2, 29, 3);

        // tick coinciding with accept becomes pending
        en_day = 1'b1;
        accept_req(2024, 2, 28);
        en_day = 1'b0;
        repeat (3) @(negedge clk);
        chk_date("sim.commit", 2024, 2, 28, 4);
        @(negedge clk);
        chk_date("sim.step", 2024, 2, 29, 5);

        load(9999, 12, 31);
        chk_date("y9999", 9999, 12, 31, 6);
        tick();
        chk_date("wrap", 1, 1, 1, 2);
        chk("wrap.ny", 32'(new_year), 1);
        chk("wrap.sat", 32'(sat_flag), 0);
        chk("sat.year", 32'(s_year), 9999);
        chk("sat.month", 32'(s_month), 12);
        chk("sat.day", 32'(s_day), 31);
        chk("sat.week", 32'(s_week), 6);
        chk("sat.flag", 32'(s_sat_flag), 1);
        chk("sat.ny", 32'(s_new_year), 0);
        @(negedge clk);
        chk("wrap.ny_clr", 32'(new_year), 0);
        chk("sat.sticky", 32'(s_sat_flag), 1);

        accept_req(2024, 12, 31);
        chk("sat.clr", 32'(s_sat_flag), 0);
        en_day = 1'b1;
        @(negedge clk);
        en_day = 1'b0;
        repeat (2) @(negedge clk);
        chk_date("pend.commit", 2024, 12, 31, 3);
        chk("pend.ny0", 32'(new_year), 0);
        @(negedge clk);
        chk_date("pend.step", 2025, 1, 1, 4);
        chk("pend.ny", 32'(new_year), 1);

        accept_req(2030, 6, 15);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_date("rst_week", 1, 1, 1, 2);
        chk("rst_week.rdy", 32'(set_ready), 1);
        repeat (3) @(negedge clk);
        chk_date("rst_week.nocommit", 1, 1, 1, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1);
    end

endmodule
